// File: rtl/id_ex_stage_pkg.sv
// Shared definitions for the ID/EX pipeline register and its hazard unit.
// Holds the ALU op encodings, the hard-wired zero register index, the
// forwarding-source select and the control bundle with its bubble value.
package id_ex_stage_pkg;

  // ALU operation encodings understood by the EX stage
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  // r0 always reads zero, so it never creates a dependency
  localparam logic [4:0] REG_ZERO = 5'd0;

  // Where an operand is taken from when it is captured into ID/EX
  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_MEM = 2'd1,
    FWD_WB  = 2'd2
  } fwd_sel_e;

  // Downstream control carried alongside the operands
  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
  } ex_ctrl_t;

  // A bubble does nothing anywhere downstream
  localparam ex_ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Combinational RAW-hazard stall and operand-forwarding select generation.
// Build option ID_EX_FORWARD_EN: when defined, only load-use stalls and the
// operands are forwarded from MEM/WB; otherwise every RAW hazard against EX
// or MEM stalls and operands always come from the register file.
module hazard_detect
  import id_ex_stage_pkg::*;
#(
  parameter int RW = 5
) (
  input  logic          i_id_valid,
  input  logic [RW-1:0] i_rs,
  input  logic [RW-1:0] i_rt,
  input  logic          i_uses_rs,
  input  logic          i_uses_rt,
  input  logic          i_ex_valid,
  input  logic          i_ex_reg_write,
  input  logic          i_ex_mem_read,
  input  logic [RW-1:0] i_ex_rd,
  input  logic [RW-1:0] i_mem_rd,
  input  logic          i_mem_reg_write,
  input  logic [RW-1:0] i_wb_rd,
  input  logic          i_wb_reg_write,
  output logic          o_stall,
  output fwd_sel_e      o_fwd_a,
  output fwd_sel_e      o_fwd_b
);

  // A source depends on a destination only if it is really read, is not r0,
  // and the producer will actually write that same register
  function automatic logic srcHit(input logic used, input logic [RW-1:0] src,
                                  input logic dstWr, input logic [RW-1:0] dst);
    return used && (src != RW'(REG_ZERO)) && dstWr && (src == dst);
  endfunction

  logic w_rs_ex, w_rt_ex, w_rs_mem, w_rt_mem;

  assign w_rs_ex  = srcHit(i_uses_rs, i_rs, i_ex_valid & i_ex_reg_write, i_ex_rd);
  assign w_rt_ex  = srcHit(i_uses_rt, i_rt, i_ex_valid & i_ex_reg_write, i_ex_rd);
  assign w_rs_mem = srcHit(i_uses_rs, i_rs, i_mem_reg_write, i_mem_rd);
  assign w_rt_mem = srcHit(i_uses_rt, i_rt, i_mem_reg_write, i_mem_rd);

`ifdef ID_EX_FORWARD_EN
  logic w_rs_wb, w_rt_wb;

  assign w_rs_wb = srcHit(i_uses_rs, i_rs, i_wb_reg_write, i_wb_rd);
  assign w_rt_wb = srcHit(i_uses_rt, i_rt, i_wb_reg_write, i_wb_rd);

  // Only a load in EX cannot be forwarded in time
  assign o_stall = i_id_valid & i_ex_valid & i_ex_mem_read & (w_rs_ex | w_rt_ex);

  // Youngest producer wins: MEM result before WB data before register file
  always_comb begin
    o_fwd_a = FWD_RF;
    o_fwd_b = FWD_RF;
    if (w_rs_mem)      o_fwd_a = FWD_MEM;
    else if (w_rs_wb)  o_fwd_a = FWD_WB;
    if (w_rt_mem)      o_fwd_b = FWD_MEM;
    else if (w_rt_wb)  o_fwd_b = FWD_WB;
  end
`else
  logic w_unused;

  // WB is not checked: the register file writes in the first half-cycle
  assign o_stall  = i_id_valid & (w_rs_ex | w_rt_ex | w_rs_mem | w_rt_mem);
  assign o_fwd_a  = FWD_RF;
  assign o_fwd_b  = FWD_RF;
  assign w_unused = ^{i_ex_mem_read, i_wb_rd, i_wb_reg_write};
`endif

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with RAW-hazard stall, branch flush and a
// saturating stall-cycle counter. Build option ID_EX_FORWARD_EN switches the
// hazard unit to load-use stalls with MEM/WB operand forwarding.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int DW    = 32,
  parameter int RW    = 5,
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_id_valid,
  input  logic [RW-1:0]    i_id_rs,
  input  logic [RW-1:0]    i_id_rt,
  input  logic             i_id_uses_rs,
  input  logic             i_id_uses_rt,
  input  logic [RW-1:0]    i_id_rd,
  input  logic [DW-1:0]    i_id_a,
  input  logic [DW-1:0]    i_id_b,
  input  logic [DW-1:0]    i_id_imm,
  input  logic             i_id_alu_src,
  input  logic [3:0]       i_id_alu_oper,
  input  logic             i_id_reg_write,
  input  logic             i_id_mem_read,
  input  logic             i_id_mem_write,
  input  logic             i_id_mem_to_reg,
  input  logic [RW-1:0]    i_mem_rd,
  input  logic             i_mem_reg_write,
  input  logic [DW-1:0]    i_mem_result,
  input  logic [RW-1:0]    i_wb_rd,
  input  logic             i_wb_reg_write,
  input  logic [DW-1:0]    i_wb_result,
  input  logic             i_flush,
  output logic             o_stall,
  output logic             o_ex_valid,
  output logic [DW-1:0]    o_ex_a,
  output logic [DW-1:0]    o_ex_b,
  output logic [DW-1:0]    o_ex_store_data,
  output logic [3:0]       o_ex_alu_oper,
  output logic [RW-1:0]    o_ex_rd,
  output logic             o_ex_reg_write,
  output logic             o_ex_mem_read,
  output logic             o_ex_mem_write,
  output logic             o_ex_mem_to_reg,
  output logic [CNT_W-1:0] o_stall_cnt
);

  logic             r_valid;
  logic [DW-1:0]    r_a;
  logic [DW-1:0]    r_b;
  logic [DW-1:0]    r_store_data;
  logic [3:0]       r_alu_oper;
  logic [RW-1:0]    r_rd;
  ex_ctrl_t         r_ctrl;
  logic [CNT_W-1:0] r_stall_cnt;

  logic             w_stall;
  fwd_sel_e         w_fwd_a;
  fwd_sel_e         w_fwd_b;
  logic [DW-1:0]    w_a;
  logic [DW-1:0]    w_rt_val;
  ex_ctrl_t         w_id_ctrl;

  hazard_detect #(.RW(RW)) u_hazard (
    .i_id_valid      (i_id_valid),
    .i_rs            (i_id_rs),
    .i_rt            (i_id_rt),
    .i_uses_rs       (i_id_uses_rs),
    .i_uses_rt       (i_id_uses_rt),
    .i_ex_valid      (r_valid),
    .i_ex_reg_write  (r_ctrl.reg_write),
    .i_ex_mem_read   (r_ctrl.mem_read),
    .i_ex_rd         (r_rd),
    .i_mem_rd        (i_mem_rd),
    .i_mem_reg_write (i_mem_reg_write),
    .i_wb_rd         (i_wb_rd),
    .i_wb_reg_write  (i_wb_reg_write),
    .o_stall         (w_stall),
    .o_fwd_a         (w_fwd_a),
    .o_fwd_b         (w_fwd_b)
  );

  // While reset is held the pipeline is considered empty, so never stall
  assign o_stall = w_stall & i_rst_n;

  assign w_id_ctrl = '{reg_write:  i_id_reg_write,
                       mem_read:   i_id_mem_read,
                       mem_write:  i_id_mem_write,
                       mem_to_reg: i_id_mem_to_reg};

  // Operand source selection; in the stall-only build the selects are constant
  always_comb begin
    w_a      = i_id_a;
    w_rt_val = i_id_b;
    case (w_fwd_a)
      FWD_MEM: w_a = i_mem_result;
      FWD_WB:  w_a = i_wb_result;
      default: w_a = i_id_a;
    endcase
    case (w_fwd_b)
      FWD_MEM: w_rt_val = i_mem_result;
      FWD_WB:  w_rt_val = i_wb_result;
      default: w_rt_val = i_id_b;
    endcase
  end

  // Pipeline register: flush or stall inject a bubble, otherwise capture ID
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid      <= 1'b0;
      r_a          <= '0;
      r_b          <= '0;
      r_store_data <= '0;
      r_alu_oper   <= ALU_ADD;
      r_rd         <= '0;
      r_ctrl       <= CTRL_BUBBLE;
    end else if (i_flush || w_stall) begin
      r_valid      <= 1'b0;
      r_a          <= '0;
      r_b          <= '0;
      r_store_data <= '0;
      r_alu_oper   <= ALU_ADD;
      r_rd         <= '0;
      r_ctrl       <= CTRL_BUBBLE;
    end else begin
      r_valid      <= i_id_valid;
      r_a          <= w_a;
      r_b          <= i_id_alu_src ? i_id_imm : w_rt_val;
      r_store_data <= w_rt_val;
      r_alu_oper   <= i_id_alu_oper;
      r_rd         <= i_id_rd;
      r_ctrl       <= i_id_valid ? w_id_ctrl : CTRL_BUBBLE;
    end
  end

  // Saturating count of cycles lost to stalls; flushed cycles are not stalls
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_stall_cnt <= '0;
    end else if (w_stall && !i_flush && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign o_ex_valid      = r_valid;
  assign o_ex_a          = r_a;
  assign o_ex_b          = r_b;
  assign o_ex_store_data = r_store_data;
  assign o_ex_alu_oper   = r_alu_oper;
  assign o_ex_rd         = r_rd;
  assign o_ex_reg_write  = r_ctrl.reg_write;
  assign o_ex_mem_read   = r_ctrl.mem_read;
  assign o_ex_mem_write  = r_ctrl.mem_write;
  assign o_ex_mem_to_reg = r_ctrl.mem_to_reg;
  assign o_stall_cnt     = r_stall_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios with literal expectations plus a
// randomized stream checked every cycle against a behavioural model.
// Honours ID_EX_FORWARD_EN the same way as the design.
module tb_id_ex_stage;
  import id_ex_stage_pkg::*;

  localparam int DW    = 32;
  localparam int RW    = 5;
  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic rstN;
  logic idValid, usesRs, usesRt, aluSrc, regWrite, memRead, memWrite, memToReg;
  logic [RW-1:0] rs, rt, rd, memRd, wbRd;
  logic [DW-1:0] idA, idB, imm, memResult, wbResult;
  logic [3:0] aluOper;
  logic memRegWrite, wbRegWrite, flush;

  logic stall, exValid, exRegWrite, exMemRead, exMemWrite, exMemToReg;
  logic [DW-1:0] exA, exB, exStoreData;
  logic [3:0] exAluOper;
  logic [RW-1:0] exRd;
  logic [CNT_W-1:0] stallCnt;

  int compared = 0;
  int mismatched = 0;
  logic checkEn = 1'b0;
  int litCnt = 0;

  // Model of what EX must hold, plus what the MEM stage would hold
  logic mValid, mRw, mMr, mMw, mMtr;
  logic [DW-1:0] mA, mB, mSd;
  logic [3:0] mOp;
  logic [RW-1:0] mRd, pipeMemRd;
  logic [CNT_W-1:0] mCnt;
  logic pipeMemRw;

  id_ex_stage #(.DW(DW), .RW(RW), .CNT_W(CNT_W)) dut (
    .i_clk(clk), .i_rst_n(rstN),
    .i_id_valid(idValid), .i_id_rs(rs), .i_id_rt(rt),
    .i_id_uses_rs(usesRs), .i_id_uses_rt(usesRt), .i_id_rd(rd),
    .i_id_a(idA), .i_id_b(idB), .i_id_imm(imm), .i_id_alu_src(aluSrc),
    .i_id_alu_oper(aluOper), .i_id_reg_write(regWrite), .i_id_mem_read(memRead),
    .i_id_mem_write(memWrite), .i_id_mem_to_reg(memToReg),
    .i_mem_rd(memRd), .i_mem_reg_write(memRegWrite), .i_mem_result(memResult),
    .i_wb_rd(wbRd), .i_wb_reg_write(wbRegWrite), .i_wb_result(wbResult),
    .i_flush(flush), .o_stall(stall), .o_ex_valid(exValid), .o_ex_a(exA),
    .o_ex_b(exB), .o_ex_store_data(exStoreData), .o_ex_alu_oper(exAluOper),
    .o_ex_rd(exRd), .o_ex_reg_write(exRegWrite), .o_ex_mem_read(exMemRead),
    .o_ex_mem_write(exMemWrite), .o_ex_mem_to_reg(exMemToReg),
    .o_stall_cnt(stallCnt)
  );

  always #5 clk = ~clk;

  // Does this source have to wait for an older instruction?
  function automatic logic srcHazard(input logic used, input logic [RW-1:0] src);
    if (!used || src == 0) return 1'b0;
`ifdef ID_EX_FORWARD_EN
    return mValid && mMr && mRw && (src == mRd);
`else
    return (mValid && mRw && (src == mRd)) || (memRegWrite && (src == memRd));
`endif
  endfunction

  function automatic logic modelStall();
    return rstN && idValid && (srcHazard(usesRs, rs) || srcHazard(usesRt, rt));
  endfunction

  // Value an operand must carry into EX
  function automatic logic [DW-1:0] fwdValue(input logic used, input logic [RW-1:0] src,
                                             input logic [DW-1:0] rf);
`ifdef ID_EX_FORWARD_EN
    if (used && src != 0 && memRegWrite && src == memRd) return memResult;
    if (used && src != 0 && wbRegWrite && src == wbRd) return wbResult;
`endif
    return rf;
  endfunction

  // Behavioural model of the EX-side contents
  always @(posedge clk or negedge rstN) begin : modelProc
    logic st;
    logic [DW-1:0] rtv;
    if (!rstN) begin
      mValid <= 0; mA <= 0; mB <= 0; mSd <= 0; mOp <= ALU_ADD; mRd <= 0;
      mRw <= 0; mMr <= 0; mMw <= 0; mMtr <= 0; mCnt <= 0;
      pipeMemRd <= 0; pipeMemRw <= 0;
    end else begin
      st = modelStall();
      pipeMemRd <= mRd;
      pipeMemRw <= mValid && mRw;
      if (flush || st) begin
        mValid <= 0; mA <= 0; mB <= 0; mSd <= 0; mOp <= ALU_ADD; mRd <= 0;
        mRw <= 0; mMr <= 0; mMw <= 0; mMtr <= 0;
      end else begin
        rtv = fwdValue(usesRt, rt, idB);
        mValid <= idValid;
        mA <= fwdValue(usesRs, rs, idA);
        mB <= aluSrc ? imm : rtv;
        mSd <= rtv;
        mOp <= aluOper;
        mRd <= rd;
        mRw <= idValid && regWrite;
        mMr <= idValid && memRead;
        mMw <= idValid && memWrite;
        mMtr <= idValid && memToReg;
      end
      if (st && !flush && mCnt != {CNT_W{1'b1}}) mCnt <= mCnt + 1'b1;
    end
  end

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic checkOutput();
    cmp("stall", stall, modelStall());
    cmp("ex_valid", exValid, mValid);
    cmp("ex_a", exA, mA);
    cmp("ex_b", exB, mB);
    cmp("ex_store_data", exStoreData, mSd);
    cmp("ex_alu_oper", exAluOper, mOp);
    cmp("ex_rd", exRd, mRd);
    cmp("ex_reg_write", exRegWrite, mRw);
    cmp("ex_mem_read", exMemRead, mMr);
    cmp("ex_mem_write", exMemWrite, mMw);
    cmp("ex_mem_to_reg", exMemToReg, mMtr);
    cmp("stall_cnt", stallCnt, mCnt);
  endtask

  // Single compare process, away from the active edge
  always @(negedge clk) if (checkEn) checkOutput();

  task automatic setIdle();
    idValid = 0; usesRs = 0; usesRt = 0; rs = 0; rt = 0; rd = 0;
    idA = 0; idB = 0; imm = 0; aluSrc = 0; aluOper = ALU_ADD;
    regWrite = 0; memRead = 0; memWrite = 0; memToReg = 0;
    memRd = 0; memRegWrite = 0; memResult = 0;
    wbRd = 0; wbRegWrite = 0; wbResult = 0; flush = 0;
  endtask

  task automatic setInstr(input logic [RW-1:0] s, input logic [RW-1:0] t,
                          input logic [RW-1:0] d, input logic [DW-1:0] a,
                          input logic [DW-1:0] b, input logic [3:0] op,
                          input logic load);
    idValid = 1; usesRs = 1; usesRt = 1; rs = s; rt = t; rd = d;
    idA = a; idB = b; imm = 32'hFFFF_0004; aluSrc = 0; aluOper = op;
    regWrite = 1; memRead = load; memWrite = 0; memToReg = load;
  endtask

  task automatic nextCycle();
    @(posedge clk); #2;
  endtask

  // One random cycle; MEM usually mirrors what the model just retired from EX
  task automatic applyStimulus();
    nextCycle();
    rstN = ($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1;
    idValid = ($urandom_range(0, 4) != 0);
    usesRs = $urandom_range(0, 1); usesRt = $urandom_range(0, 1);
    rs = RW'($urandom_range(0, 3)); rt = RW'($urandom_range(0, 3));
    rd = RW'($urandom_range(0, 3));
    idA = $urandom; idB = $urandom; imm = $urandom;
    aluSrc = $urandom_range(0, 1); aluOper = 4'($urandom_range(0, 15));
    regWrite = $urandom_range(0, 1); memRead = $urandom_range(0, 1);
    memWrite = $urandom_range(0, 1); memToReg = $urandom_range(0, 1);
    if ($urandom_range(0, 9) < 7) begin
      memRd = pipeMemRd; memRegWrite = pipeMemRw;
    end else begin
      memRd = RW'($urandom_range(0, 3)); memRegWrite = $urandom_range(0, 1);
    end
    memResult = $urandom;
    wbRd = RW'($urandom_range(0, 3)); wbRegWrite = $urandom_range(0, 1);
    wbResult = $urandom;
    flush = ($urandom_range(0, 7) == 0);
  endtask

  initial begin
    setIdle();
    rstN = 1'b1;
    #1 rstN = 1'b0;
    #2;
    cmp("rst_ex_valid", exValid, 1'b0);
    cmp("rst_stall", stall, 1'b0);
    cmp("rst_stall_cnt", stallCnt, 0);
    cmp("rst_alu_oper", exAluOper, ALU_ADD);
    checkEn = 1'b1;
    repeat (2) @(posedge clk);
    #2 rstN = 1'b1;

    // Independent add r3,r1,r2
    nextCycle(); setInstr(1, 2, 3, 5, 7, ALU_ADD, 0);
    nextCycle(); setIdle();
    @(negedge clk);
    cmp("add_ex_a", exA, 5);
    cmp("add_ex_b", exB, 7);
    cmp("add_ex_rd", exRd, 3);
    cmp("add_reg_write", exRegWrite, 1'b1);
    cmp("add_stall", stall, 1'b0);

`ifdef ID_EX_FORWARD_EN
    // lw r5 then add r6,r5,r5: exactly one stall, then MEM forwarding
    nextCycle(); setInstr(1, 2, 5, 9, 9, ALU_ADD, 1);
    nextCycle(); setInstr(5, 5, 6, 3, 4, ALU_ADD, 0);
    @(negedge clk); cmp("lu_stall1", stall, 1'b1);
    nextCycle(); memRd = 5; memRegWrite = 1; memResult = 32'hAAAA;
    @(negedge clk); cmp("lu_stall2", stall, 1'b0);
    nextCycle(); setIdle();
    @(negedge clk);
    litCnt = 1;
    cmp("lu_ex_a", exA, 32'hAAAA);
    cmp("lu_ex_b", exB, 32'hAAAA);
    cmp("lu_cnt", stallCnt, litCnt);
    // add r3 then or r7,r3,r3 forwarded from MEM
    nextCycle(); setInstr(1, 2, 3, 1, 2, ALU_ADD, 0);
    nextCycle(); setInstr(3, 3, 7, 8, 8, ALU_OR, 0);
    memRd = 3; memRegWrite = 1; memResult = 32'h1234;
    @(negedge clk); cmp("fw_stall", stall, 1'b0);
    nextCycle(); setIdle();
    @(negedge clk);
    cmp("fw_ex_a", exA, 32'h1234);
    cmp("fw_ex_b", exB, 32'h1234);
`else
    // add r3 then sub r4,r3,r1: two stalls (EX match, MEM match)
    nextCycle(); setInstr(1, 2, 3, 1, 2, ALU_ADD, 0);
    nextCycle(); setInstr(3, 1, 4, 11, 22, ALU_SUB, 0);
    @(negedge clk); cmp("raw_stall_ex", stall, 1'b1);
    nextCycle(); memRd = 3; memRegWrite = 1;
    @(negedge clk);
    cmp("raw_stall_mem", stall, 1'b1);
    cmp("raw_bubble", exValid, 1'b0);
    nextCycle(); memRegWrite = 0;
    @(negedge clk);
    litCnt = 2;
    cmp("raw_release", stall, 1'b0);
    cmp("raw_cnt", stallCnt, litCnt);
    nextCycle(); setIdle();
    @(negedge clk);
    cmp("raw_sub_valid", exValid, 1'b1);
    cmp("raw_sub_a", exA, 11);
    cmp("raw_sub_rd", exRd, 4);
    cmp("raw_sub_op", exAluOper, ALU_SUB);
`endif

    // r0 as destination never creates a dependency
    nextCycle(); setInstr(1, 2, 0, 1, 2, ALU_ADD, 0);
    nextCycle(); setInstr(0, 0, 6, 1, 2, ALU_ADD, 0);
    @(negedge clk); cmp("r0_stall", stall, 1'b0);
    nextCycle(); setIdle();

    // Flush together with a load-use stall: bubble, counter untouched
    nextCycle(); setInstr(1, 2, 3, 1, 2, ALU_ADD, 1);
    nextCycle(); setInstr(3, 1, 4, 1, 2, ALU_SUB, 0); flush = 1;
    @(negedge clk); cmp("fl_stall", stall, 1'b1);
    nextCycle(); setIdle();
    @(negedge clk);
    cmp("fl_bubble", exValid, 1'b0);
    cmp("fl_cnt", stallCnt, litCnt);

`ifndef ID_EX_FORWARD_EN
    // Counter saturation, then reset in the middle of a stall
    nextCycle(); setInstr(2, 1, 5, 1, 2, ALU_ADD, 0);
    memRd = 2; memRegWrite = 1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    cmp("sat_cnt", stallCnt, {CNT_W{1'b1}});
    cmp("sat_stall", stall, 1'b1);
    #1 rstN = 1'b0;
    #1;
    cmp("mid_rst_stall", stall, 1'b0);
    cmp("mid_rst_cnt", stallCnt, 0);
    cmp("mid_rst_valid", exValid, 1'b0);
    cmp("mid_rst_op", exAluOper, ALU_ADD);
    nextCycle(); rstN = 1'b1; setIdle();
`endif

    repeat (3000) applyStimulus();
    nextCycle(); rstN = 1'b1; setIdle();
    @(negedge clk);
    checkEn = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
